// File: rtl/riscv_v_pkg.sv
// Shared RISC-V vector types: data, mask and register-index widths plus the
// writeback queue entry carried from execute to retirement.
package riscv_v_pkg;

    localparam int RISCV_XLEN        = 32;
    localparam int RISCV_V_VLEN      = 128;
    localparam int RISCV_V_ELEN      = 32;
    localparam int RISCV_V_NUM_ELEMS = RISCV_V_VLEN / RISCV_V_ELEN;
    localparam int RISCV_V_NUM_VREGS = 32;

    typedef logic [RISCV_XLEN-1:0]                riscv_data_t;
    typedef logic [RISCV_V_VLEN-1:0]              riscv_v_wb_data_t;
    typedef logic [RISCV_V_NUM_ELEMS-1:0]         riscv_v_mask_t;
    typedef logic [$clog2(RISCV_V_NUM_VREGS)-1:0] riscv_v_vreg_idx_t;

    typedef struct packed {
        riscv_v_wb_data_t  vec_result;
        riscv_data_t       int_result;
        riscv_v_vreg_idx_t dst_reg;
        riscv_v_mask_t     wr_mask;
        logic              wr_vec;
        logic              wr_int;
    } riscv_v_wb_entry_t;

endpackage

// File: rtl/riscv_v_wb_unit_if.sv
// Execute-result, VRF-write and scalar-return signals of the vector writeback unit.
// The unit takes the slave view; the producer/consumer side takes the master view.
interface riscv_v_wb_unit_if
    import riscv_v_pkg::*;
();
    logic              exe_valid;
    logic              exe_ready;
    riscv_v_wb_data_t  exe_vec_result;
    riscv_data_t       exe_int_result;
    riscv_v_vreg_idx_t exe_dst_reg;
    riscv_v_mask_t     exe_wr_mask;
    logic              exe_wr_vec;
    logic              exe_wr_int;

    logic              vrf_we;
    riscv_v_vreg_idx_t vrf_waddr;
    riscv_v_wb_data_t  vrf_wdata;
    riscv_v_mask_t     vrf_wmask;

    logic              int_valid;
    logic              int_ready;
    riscv_data_t       int_data;

    modport master (
        output exe_valid, exe_vec_result, exe_int_result, exe_dst_reg,
               exe_wr_mask, exe_wr_vec, exe_wr_int, int_ready,
        input  exe_ready, vrf_we, vrf_waddr, vrf_wdata, vrf_wmask,
               int_valid, int_data
    );

    modport slave (
        input  exe_valid, exe_vec_result, exe_int_result, exe_dst_reg,
               exe_wr_mask, exe_wr_vec, exe_wr_int, int_ready,
        output exe_ready, vrf_we, vrf_waddr, vrf_wdata, vrf_wmask,
               int_valid, int_data
    );
endinterface

// File: rtl/riscv_v_wb_fifo.sv
// In-order DEPTH-entry queue of writeback entries. Pointers carry one extra
// wrap bit so full/empty fall out of a compare; flush beats push and pop.
module riscv_v_wb_fifo
    import riscv_v_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int PTR_W = IDX_W + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_flush,
    input  logic              i_push,
    input  riscv_v_wb_entry_t i_push_entry,
    input  logic              i_pop,
    output riscv_v_wb_entry_t o_head,
    output logic [IDX_W-1:0]  o_head_idx,
    output logic [PTR_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic [DEPTH-1:0]  o_slot_wr_vec,
    output riscv_v_vreg_idx_t o_slot_dst [DEPTH]
);

    riscv_v_wb_entry_t r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic              w_push;
    logic              w_pop;

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]) &&
                        (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]);
    assign o_count    = r_wr_ptr - r_rd_ptr;
    assign o_head_idx = r_rd_ptr[IDX_W-1:0];
    assign o_head     = r_mem[r_rd_ptr[IDX_W-1:0]];
    assign w_push     = i_push && !o_full && !i_flush;
    assign w_pop      = i_pop && !o_empty && !i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[IDX_W-1:0]] <= i_push_entry;
    end

    // Occupied-slot scan view: a slot is live when its distance from the head is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            o_slot_wr_vec[i] = ({1'b0, IDX_W'(i) - r_rd_ptr[IDX_W-1:0]} < o_count) && r_mem[i].wr_vec;
            o_slot_dst[i]    = r_mem[i].dst_reg;
        end
    end

endmodule

// File: rtl/riscv_v_wb_unit.sv
// Vector writeback unit: queues execute results, writes the VRF, returns scalar
// results to the integer core and reports destinations still in flight.
module riscv_v_wb_unit
    import riscv_v_pkg::*;
#(
    parameter  int DEPTH     = 4,
    parameter  int NUM_VREGS = RISCV_V_NUM_VREGS,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    riscv_v_wb_unit_if.slave     bus,
    output logic [NUM_VREGS-1:0] o_pending_vreg,
    output logic [CNT_W-1:0]     o_count
);

    riscv_v_wb_entry_t w_push_entry;
    riscv_v_wb_entry_t w_head;
    logic [IDX_W-1:0]  w_head_idx;
    logic              w_full;
    logic              w_empty;
    logic [DEPTH-1:0]  w_slot_wr_vec;
    riscv_v_vreg_idx_t w_slot_dst [DEPTH];
    logic              w_need_vec;
    logic              w_need_int;
    logic              w_pop;
    logic              r_vec_done;
    logic              r_int_done;

    assign w_push_entry = '{vec_result: bus.exe_vec_result, int_result: bus.exe_int_result,
                            dst_reg:    bus.exe_dst_reg,    wr_mask:    bus.exe_wr_mask,
                            wr_vec:     bus.exe_wr_vec,     wr_int:     bus.exe_wr_int};

    riscv_v_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_flush      (i_flush),
        .i_push       (bus.exe_valid),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop),
        .o_head       (w_head),
        .o_head_idx   (w_head_idx),
        .o_count      (o_count),
        .o_full       (w_full),
        .o_empty      (w_empty),
        .o_slot_wr_vec(w_slot_wr_vec),
        .o_slot_dst   (w_slot_dst)
    );

    assign bus.exe_ready = !w_full;
    assign w_need_vec    = !w_empty && w_head.wr_vec && !r_vec_done;
    assign w_need_int    = !w_empty && w_head.wr_int && !r_int_done;
    // The VRF write always completes in its cycle, so only the scalar handshake can hold the head.
    assign w_pop         = !w_empty && (!w_need_int || bus.int_ready);

    always_comb begin
        bus.vrf_we    = w_need_vec;
        bus.vrf_waddr = w_need_vec ? w_head.dst_reg    : '0;
        bus.vrf_wdata = w_need_vec ? w_head.vec_result : '0;
        bus.vrf_wmask = w_need_vec ? w_head.wr_mask    : '0;
        bus.int_valid = w_need_int;
        bus.int_data  = w_need_int ? w_head.int_result : '0;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vec_done <= 1'b0;
            r_int_done <= 1'b0;
        end else if (i_flush || w_pop) begin
            r_vec_done <= 1'b0;
            r_int_done <= 1'b0;
        end else begin
            if (w_need_vec)                   r_vec_done <= 1'b1;
            if (w_need_int && bus.int_ready)  r_int_done <= 1'b1;
        end
    end

    always_comb begin
        o_pending_vreg = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_slot_wr_vec[i] && !(r_vec_done && (IDX_W'(i) == w_head_idx))) begin
                for (int r = 0; r < NUM_VREGS; r++) begin
                    if (w_slot_dst[i] == riscv_v_vreg_idx_t'(r)) o_pending_vreg[r] = 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/riscv_v_wb_unit.md
# riscv_v_wb_unit

Vector writeback unit: the consumer end of the vector execute ALU result interface. It accepts one result per cycle from execute (vector writeback data plus optional scalar result) through a valid/ready handshake and buffers it in a DEPTH-entry in-order queue. It retires entries by writing the vector register file (VRF) and returning scalar results to the integer core over a valid/ready handshake. It also exports a pending-destination bitmap that issue uses for RAW stalls.

## Interface
- DEPTH, 4, queue entries; power of two, at least 2.
- NUM_VREGS, 32, architectural vector registers.
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- flush  in  1  synchronous; discards all entries.
- exe_valid  in  1  execute presents a result.
- exe_ready  out  1  unit can accept.
- exe_vec_result  in  riscv_v_wb_data_t  vector result.
- exe_int_result  in  riscv_data_t  scalar result (v2i).
- exe_dst_reg  in  $clog2(NUM_VREGS)  destination vector register.
- exe_wr_mask  in  riscv_v_mask_t  per-element write enable.
- exe_wr_vec  in  1  result writes VRF.
- exe_wr_int  in  1  result returns to integer core.
- vrf_we  out  1  VRF write strobe; always accepted.
- vrf_waddr  out  $clog2(NUM_VREGS)  write register.
- vrf_wdata  out  riscv_v_wb_data_t  write data.
- vrf_wmask  out  riscv_v_mask_t  element enables.
- int_valid  out  1  scalar result valid.
- int_ready  in  1  integer core accepts.
- int_data  out  riscv_data_t  scalar result.
- pending_vreg  out  NUM_VREGS  bit r set: a queued entry will still write vreg r.
- count  out  $clog2(DEPTH)+1  occupancy.

## Operation
- Push: exe_valid & exe_ready stores {vec_result, int_result, dst_reg, wr_mask, wr_vec, wr_int} at the write pointer. exe_ready = (count != DEPTH); it does not depend on a same-cycle pop (no full-queue pass-through).
- An entry with neither wr_vec nor wr_int is pushed and retires one cycle after it reaches the head.
- Head states (per-head flags vec_done and int_done, cleared on every pop):
  - WAIT_VEC: wr_vec & !vec_done. vrf_we=1 for exactly one cycle; vrf_* driven from the head; vec_done set.
  - WAIT_INT: wr_int & !int_done. int_valid=1 and int_data stable until int_ready; int_done set on handshake.
  - These two states run concurrently, so the vector write and the scalar handshake may complete in the same cycle.
- Pop: occurs in a cycle where each required part is already done or completes this cycle. The read pointer advances and the next entry becomes head the following cycle.
- Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH. Full and empty are derived from pointer MSB equality.
- pending_vreg is the OR of onehot(dst_reg) over valid entries with wr_vec, excluding the head once vec_done is set. It is combinational from registered state only.
- Simultaneous push and pop: count is unchanged; both take effect.
- flush: count→0, pointers→0, done flags cleared; int_valid drops the next cycle even if a handshake is outstanding. A push in the same cycle as flush is discarded. Flush has priority over push and pop.

## Timing
- Reset values: exe_ready=1, vrf_we=0, int_valid=0, pending_vreg=0, count=0, vrf_waddr/vrf_wdata/vrf_wmask/int_data=0. Reset asserted mid-operation drops all entries immediately (asynchronous).
- Latency: a push in cycle N gives vrf_we in cycle N+1 at the earliest (empty queue). Sustained throughput is 1 entry/cycle when int_ready stays high.
- vrf_we is never asserted twice for the same entry. int_valid, once high, holds with stable data until int_ready or flush.
- pending_vreg bit sets in the cycle after the push and clears in the cycle after vrf_we.

## Structure
- riscv_v_pkg gains: riscv_v_wb_entry_t (packed entry struct), riscv_v_vreg_idx_t, and RISCV_V_NUM_VREGS=32.
- One sub-module, riscv_v_wb_fifo: generic DEPTH-deep queue of riscv_v_wb_entry_t with push, pop, head, count, and flush. Head flags, handshakes, and pending_vreg logic stay in riscv_v_wb_unit.

## Test plan
- Single vector op: push dst=5, wr_vec, mask=all 1s, data=A5.. → vrf_we one cycle later with waddr=5, wdata=A5..; pending_vreg[5] high for exactly 1 cycle; count returns to 0.
- Back-pressure: push 4 v2i ops with int_ready=0 → exe_ready=0 after the 4th push; int_valid held with the first entry's data. Raise int_ready → 4 results in order over 4 cycles; exe_ready reasserts in the cycle after the first pop.
- Mixed entry (wr_vec & wr_int) with int_ready=0 for 3 cycles → exactly one vrf_we; pop only on the int handshake; the next head is not written early.
- Full-queue push and pop same cycle: count stays 4 with exe_ready=0 → push is refused; next cycle count=3 and exe_ready=1.
- Flush with 3 entries and int_valid pending, plus a simultaneous push → next cycle count=0, int_valid=0, pending_vreg=0; no vrf_we for any discarded entry.
- Async reset asserted mid-handshake, between clock edges → outputs reach reset values immediately, and the pointer-wrap sequence restarts cleanly after 2*DEPTH+1 pushes.
